// File: rtl/rtc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rtc_ctrl_pkg : state codes, field selects, BCD limits and repeat timing
//                shared by the stopwatch set controller.        Rev 1.0
// ============================================================================
package rtc_ctrl_pkg;

  typedef enum logic [2:0] {
    STOP    = 3'd0,
    RUN     = 3'd1,
    SET_MIN = 3'd2,
    SET_S   = 3'd3,
    SET_MS  = 3'd4,
    LOAD    = 3'd5
  } rtc_state_e;

  typedef enum logic [1:0] {
    FIELD_MIN = 2'd0,
    FIELD_S   = 2'd1,
    FIELD_MS  = 2'd2
  } rtc_field_e;

  localparam logic [3:0] TENS_LIMIT_MIN_S = 4'd5;
  localparam logic [3:0] TENS_LIMIT_MS    = 4'd9;

  localparam int unsigned REPEAT_DELAY  = 25_000_000;
  localparam int unsigned REPEAT_PERIOD = 5_000_000;
  localparam int          HOLD_CNT_W    = 25;

  // Two-digit BCD increment; tens digit wraps to 0 after tens_limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [3:0] tens_limit);
    logic [7:0] result;
    result = value;
    if (value[3:0] >= 4'd9) begin
      result[3:0] = 4'd0;
      result[7:4] = (value[7:4] >= tens_limit) ? 4'd0 : value[7:4] + 4'd1;
    end else begin
      result[3:0] = value[3:0] + 4'd1;
    end
    return result;
  endfunction

  function automatic logic [3:0] tens_limit_of(input rtc_state_e s);
    logic [3:0] lim;
    lim = (s == SET_MS) ? TENS_LIMIT_MS : TENS_LIMIT_MIN_S;
    return lim;
  endfunction

  function automatic rtc_field_e field_of(input rtc_state_e s);
    rtc_field_e f;
    case (s)
      SET_S:   f = FIELD_S;
      SET_MS:  f = FIELD_MS;
      default: f = FIELD_MIN;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_set_controller_if.sv
`default_nettype none
// ============================================================================
// rtc_set_controller_if : key/switch inputs and datapath control outputs.
//                                                                 Rev 1.0
// ============================================================================
interface rtc_set_controller_if;
  logic       btn_run;
  logic       btn_mode;
  logic       btn_inc;
  logic       max;
  logic       enable;
  logic       load_ms;
  logic       load_s;
  logic       load_min;
  logic [7:0] data;
  logic [2:0] mode;

  modport master (
    output btn_run, btn_mode, btn_inc, max,
    input  enable, load_ms, load_s, load_min, data, mode
  );

  modport slave (
    input  btn_run, btn_mode, btn_inc, max,
    output enable, load_ms, load_s, load_min, data, mode
  );
endinterface
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// btn_sync_edge : multi-flop synchronizer followed by a rising-edge pulse.
//                                                                 Rev 1.0
// ============================================================================
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign pulse = r_sync[STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/rtc_set_controller.sv
`default_nettype none
// ============================================================================
// rtc_set_controller : run/stop and field-by-field time-set FSM for the
// stopwatch datapath. Macro RTC_AUTO_REPEAT_EN adds hold-to-repeat. Rev 1.0
// ============================================================================
module rtc_set_controller
  import rtc_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES = 4,
  parameter int STOP_AT_MAX = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLOCK_50,
  input  logic                aclr,
  rtc_set_controller_if.slave bus
);

  logic run_edge, mode_edge, inc_edge, max_edge;
  logic run_level, mode_level, inc_level, max_level;
  logic inc_event;
  logic unused_levels;

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_run (
    .clk(CLOCK_50), .rst_n(aclr), .din(bus.btn_run),
    .level(run_level), .pulse(run_edge)
  );

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(CLOCK_50), .rst_n(aclr), .din(bus.btn_mode),
    .level(mode_level), .pulse(mode_edge)
  );

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk(CLOCK_50), .rst_n(aclr), .din(bus.btn_inc),
    .level(inc_level), .pulse(inc_edge)
  );

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_max (
    .clk(CLOCK_50), .rst_n(aclr), .din(bus.max),
    .level(max_level), .pulse(max_edge)
  );

  rtc_state_e state, state_next;
  rtc_field_e r_field, field_next;
  logic [7:0] r_edit, edit_next;
  logic [3:0] r_load_cnt, load_cnt_next;

`ifdef RTC_AUTO_REPEAT_EN
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic                  in_set;
  logic                  rep_pulse;

  assign in_set    = (state == SET_MIN) || (state == SET_S) || (state == SET_MS);
  assign rep_pulse = in_set && inc_level &&
                     (r_hold_cnt == HOLD_CNT_W'(REPEAT_DELAY - 1));

  // After the first repeat the counter is rewound so later repeats are one period apart.
  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      r_hold_cnt <= '0;
    end else if (!inc_level || !in_set || (state_next != state) || inc_edge) begin
      r_hold_cnt <= '0;
    end else if (rep_pulse) begin
      r_hold_cnt <= HOLD_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    end else begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign inc_event     = inc_edge | rep_pulse;
  assign unused_levels = ^{run_level, mode_level, max_level};
`else
  assign inc_event     = inc_edge;
  assign unused_levels = ^{run_level, mode_level, inc_level, max_level};
`endif

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      state      <= STOP;
      r_field    <= FIELD_MIN;
      r_edit     <= 8'h00;
      r_load_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      r_field    <= field_next;
      r_edit     <= edit_next;
      r_load_cnt <= load_cnt_next;
    end
  end

  // Edge priority inside each state is run > mode > inc; lower edges are dropped.
  always_comb begin
    state_next    = state;
    field_next    = r_field;
    edit_next     = r_edit;
    load_cnt_next = 4'd0;
    case (state)
      STOP: begin
        if (run_edge) begin
          state_next = RUN;
        end else if (mode_edge) begin
          state_next = SET_MIN;
          edit_next  = 8'h00;
        end
      end
      RUN: begin
        if (run_edge || ((STOP_AT_MAX != 0) && max_edge)) begin
          state_next = STOP;
        end
      end
      SET_MIN, SET_S, SET_MS: begin
        if (run_edge) begin
          state_next = STOP;
        end else if (mode_edge) begin
          state_next = LOAD;
          field_next = field_of(state);
        end else if (inc_event) begin
          edit_next = bcd_inc(r_edit, tens_limit_of(state));
        end
      end
      LOAD: begin
        if (r_load_cnt == 4'(LOAD_CYCLES - 1)) begin
          case (r_field)
            FIELD_MIN: begin
              state_next = SET_S;
              edit_next  = 8'h00;
            end
            FIELD_S: begin
              state_next = SET_MS;
              edit_next  = 8'h00;
            end
            default: state_next = STOP;
          endcase
        end else begin
          load_cnt_next = r_load_cnt + 4'd1;
        end
      end
      default: state_next = STOP;
    endcase
  end

  logic       r_enable, r_load_ms, r_load_s, r_load_min;
  logic [7:0] r_data;
  logic [2:0] r_mode;

  // data trails the edit register by one cycle, so it stays put for the
  // cycle after a strobe even though the edit register clears at that edge.
  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      r_enable   <= 1'b0;
      r_load_ms  <= 1'b0;
      r_load_s   <= 1'b0;
      r_load_min <= 1'b0;
      r_data     <= 8'h00;
      r_mode     <= STOP;
    end else begin
      r_enable   <= (state_next == RUN);
      r_load_min <= (state_next == LOAD) && (field_next == FIELD_MIN);
      r_load_s   <= (state_next == LOAD) && (field_next == FIELD_S);
      r_load_ms  <= (state_next == LOAD) && (field_next == FIELD_MS);
      r_data     <= r_edit;
      r_mode     <= state_next;
    end
  end

  assign bus.enable   = r_enable;
  assign bus.load_ms  = r_load_ms;
  assign bus.load_s   = r_load_s;
  assign bus.load_min = r_load_min;
  assign bus.data     = r_data;
  assign bus.mode     = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_rtc_set_controller.sv
`default_nettype none
// tb_rtc_set_controller : vector table, hand-written corner sequences and
// randomized button traffic against a press-level reference model.
module tb_rtc_set_controller;

  localparam int LOAD_CYCLES = 4;
  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 10;

  logic clk  = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  rtc_set_controller_if bus ();
  rtc_set_controller_if bus2 ();

  rtc_set_controller #(.LOAD_CYCLES(LOAD_CYCLES), .STOP_AT_MAX(1), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLOCK_50(clk), .aclr(aclr), .bus(bus)
  );

  rtc_set_controller #(.LOAD_CYCLES(LOAD_CYCLES), .STOP_AT_MAX(0), .SYNC_STAGES(SYNC_STAGES)) dut_free (
    .CLOCK_50(clk), .aclr(aclr), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int field;
    int val;
    int len;
    bit stable;
  } load_t;

  load_t obs_q[$];
  load_t exp_q[$];

  task automatic expect_load(input int field, input int val);
    load_t rec;
    rec.field = field; rec.val = val; rec.len = LOAD_CYCLES; rec.stable = 1'b1;
    exp_q.push_back(rec);
  endtask

  task automatic check_loads(input string tag);
    check({tag, " load count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check({tag, " load field"}, obs_q[k].field, exp_q[k].field);
      check({tag, " load data"}, obs_q[k].val, exp_q[k].val);
      check({tag, " load length"}, obs_q[k].len, exp_q[k].len);
      check({tag, " load data stable"}, int'(obs_q[k].stable), 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Strobe monitor: records each strobe burst and watches exclusivity rules.
  int cur_field = 0, cur_len = 0, cur_val = 0, prev_data = 0, viol = 0;
  bit cur_ok = 1'b0;
  always @(negedge clk) begin : monitor
    int f;
    int n;
    load_t rec;
    f = 0;
    n = 0;
    if (bus.load_min) begin f = 1; n++; end
    if (bus.load_s)   begin f = 2; n++; end
    if (bus.load_ms)  begin f = 3; n++; end
    if (!aclr) begin
      cur_field = 0;
    end else begin
      if (n > 1 || (n != 0 && bus.enable)) viol++;
      if (cur_field != 0 && f != cur_field) begin
        rec.field  = cur_field;
        rec.val    = cur_val;
        rec.len    = cur_len;
        rec.stable = cur_ok && (int'(bus.data) == cur_val);
        obs_q.push_back(rec);
        cur_field = 0;
      end
      if (f != 0) begin
        if (cur_field == 0) begin
          cur_field = f;
          cur_len   = 1;
          cur_val   = int'(bus.data);
          cur_ok    = (prev_data == int'(bus.data));
        end else begin
          cur_len++;
          if (int'(bus.data) != cur_val) cur_ok = 1'b0;
        end
      end
    end
    prev_data = int'(bus.data);
  end

  task automatic press(input bit r, input bit m, input bit i, input bit x, input int hold);
    bus.btn_run = r; bus.btn_mode = m; bus.btn_inc = i; bus.max = x;
    repeat (hold) step();
    bus.btn_run = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.max = 1'b0;
    repeat (SETTLE) step();
  endtask

  // Press-level model: state code per the published encoding, edit kept as a decimal count.
  int m_state = 0;
  int m_edit  = 0;

  function automatic int to_bcd(input int n);
    return (n / 10) * 16 + (n % 10);
  endfunction

  task automatic model(input bit r, input bit m, input bit i, input bit x);
    case (m_state)
      0: begin
        if (r) m_state = 1;
        else if (m) begin m_state = 2; m_edit = 0; end
      end
      1: if (r || x) m_state = 0;
      2, 3, 4: begin
        if (r) m_state = 0;
        else if (m) begin
          expect_load(m_state - 1, to_bcd(m_edit));
          if (m_state == 4) m_state = 0;
          else begin m_state = m_state + 1; m_edit = 0; end
        end else if (i) begin
          m_edit = (m_edit + 1) % ((m_state == 4) ? 100 : 60);
        end
      end
      default: m_state = 0;
    endcase
  endtask

  typedef struct {
    bit r, m, i;
    int reps;
    int exp_mode, exp_data;
    int ld_field, ld_val;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit m, input bit i, input int reps,
                              input int em, input int ed, input int lf, input int lv);
    vec_t v;
    v.r = r; v.m = m; v.i = i; v.reps = reps;
    v.exp_mode = em; v.exp_data = ed; v.ld_field = lf; v.ld_val = lv;
    return v;
  endfunction

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish after 90000 cycles, expected finish");
    $fatal(1, "simulation hang");
  end

  initial begin
    vec_t tbl[22];
    int found;
    int lows;
    tbl[0]  = mk(0, 1, 0, 1,   2, 'h00, 0, 0);
    tbl[1]  = mk(0, 0, 1, 7,   2, 'h07, 0, 0);
    tbl[2]  = mk(0, 1, 0, 1,   3, 'h00, 1, 'h07);
    tbl[3]  = mk(0, 0, 1, 61,  3, 'h01, 0, 0);
    tbl[4]  = mk(0, 1, 0, 1,   4, 'h00, 2, 'h01);
    tbl[5]  = mk(0, 0, 1, 100, 4, 'h00, 0, 0);
    tbl[6]  = mk(0, 1, 0, 1,   0, 'h00, 3, 'h00);
    tbl[7]  = mk(1, 0, 0, 1,   1, 'h00, 0, 0);
    tbl[8]  = mk(0, 1, 0, 1,   1, 'h00, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1,   1, 'h00, 0, 0);
    tbl[10] = mk(1, 0, 0, 1,   0, 'h00, 0, 0);
    tbl[11] = mk(0, 1, 0, 1,   2, 'h00, 0, 0);
    tbl[12] = mk(0, 0, 1, 3,   2, 'h03, 0, 0);
    tbl[13] = mk(0, 1, 0, 1,   3, 'h00, 1, 'h03);
    tbl[14] = mk(0, 0, 1, 2,   3, 'h02, 0, 0);
    tbl[15] = mk(1, 1, 1, 1,   0, 'h02, 0, 0);
    tbl[16] = mk(0, 0, 1, 1,   0, 'h02, 0, 0);
    tbl[17] = mk(0, 1, 0, 1,   2, 'h00, 0, 0);
    tbl[18] = mk(1, 1, 0, 1,   0, 'h00, 0, 0);
    tbl[19] = mk(0, 1, 1, 1,   2, 'h00, 0, 0);
    tbl[20] = mk(0, 1, 1, 1,   3, 'h00, 1, 'h00);
    tbl[21] = mk(1, 0, 0, 1,   0, 'h00, 0, 0);

    bus.btn_run = 0; bus.btn_mode = 0; bus.btn_inc = 0; bus.max = 0;
    bus2.btn_run = 0; bus2.btn_mode = 0; bus2.btn_inc = 0; bus2.max = 0;
    repeat (3) step();
    check("reset enable", int'(bus.enable), 0);
    check("reset load_min", int'(bus.load_min), 0);
    check("reset load_s", int'(bus.load_s), 0);
    check("reset load_ms", int'(bus.load_ms), 0);
    check("reset data", int'(bus.data), 'h00);
    check("reset mode", int'(bus.mode), 0);
    aclr = 1'b1;
    step();

    // Run press: enable only after the edge has crossed the synchronizer.
    bus.btn_run = 1'b1;
    repeat (SYNC_STAGES) step();
    check("run enable during sync", int'(bus.enable), 0);
    for (int k = 0; k < 3; k++) begin
      if (bus.enable) break;
      step();
    end
    check("run enable after sync", int'(bus.enable), 1);
    bus.btn_run = 1'b0;
    repeat (SETTLE) step();
    check("run mode", int'(bus.mode), 1);
    press(1, 0, 0, 0, 2);
    check("second run enable", int'(bus.enable), 0);
    check("second run mode", int'(bus.mode), 0);

    // max rising edge while running forces STOP.
    press(1, 0, 0, 0, 2);
    check("pre-max enable", int'(bus.enable), 1);
    bus.max = 1'b1;
    found = 0;
    for (int k = 0; k < SYNC_STAGES + 2; k++) begin
      step();
      if (!bus.enable) begin found = 1; break; end
    end
    check("max stops run", found, 1);
    bus.max = 1'b0;
    repeat (SETTLE) step();
    check("max mode", int'(bus.mode), 0);

    // Free-rollover instance ignores max.
    bus2.btn_run = 1'b1;
    repeat (3) step();
    bus2.btn_run = 1'b0;
    repeat (SETTLE) step();
    check("free enable", int'(bus2.enable), 1);
    bus2.max = 1'b1;
    lows = 0;
    repeat (SYNC_STAGES + 6) begin
      step();
      if (!bus2.enable) lows++;
    end
    bus2.max = 1'b0;
    check("free enable low cycles", lows, 0);
    check("free mode", int'(bus2.mode), 1);

    obs_q.delete();
    exp_q.delete();
    for (int t = 0; t < 22; t++) begin
      repeat (tbl[t].reps) press(tbl[t].r, tbl[t].m, tbl[t].i, 1'b0, 2);
      if (tbl[t].ld_field != 0) expect_load(tbl[t].ld_field, tbl[t].ld_val);
      check($sformatf("vec%0d mode", t), int'(bus.mode), tbl[t].exp_mode);
      check($sformatf("vec%0d data", t), int'(bus.data), tbl[t].exp_data);
      check_loads($sformatf("vec%0d", t));
    end

    // aclr during the second cycle of load_min truncates the strobe.
    press(0, 1, 0, 0, 2);
    press(0, 0, 1, 0, 2);
    press(0, 0, 1, 0, 2);
    bus.btn_mode = 1'b1;
    found = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.load_min) begin found = 1; break; end
    end
    check("aclr test strobe seen", found, 1);
    step();
    check("aclr test strobe cycle 2", int'(bus.load_min), 1);
    aclr = 1'b0;
    #1;
    check("aclr load_min", int'(bus.load_min), 0);
    check("aclr mode", int'(bus.mode), 0);
    check("aclr data", int'(bus.data), 'h00);
    check("aclr enable", int'(bus.enable), 0);
    bus.btn_mode = 1'b0;
    step();
    step();
    aclr = 1'b1;
    repeat (SETTLE) step();
    obs_q.delete();
    exp_q.delete();
    check("post-aclr mode", int'(bus.mode), 0);

    // A long hold of btn_inc in SET_MS gives a single increment.
    press(0, 1, 0, 0, 2);
    press(0, 1, 0, 0, 2);
    expect_load(1, 'h00);
    press(0, 1, 0, 0, 2);
    expect_load(2, 'h00);
    bus.btn_inc = 1'b1;
    repeat (200) step();
    bus.btn_inc = 1'b0;
    repeat (SETTLE) step();
    check("hold inc mode", int'(bus.mode), 4);
    check("hold inc data", int'(bus.data), 'h01);
    press(0, 1, 0, 0, 2);
    expect_load(3, 'h01);
    check("hold final mode", int'(bus.mode), 0);
    check_loads("hold");

    // Randomized presses against the model.
    aclr = 1'b0;
    step();
    aclr = 1'b1;
    step();
    obs_q.delete();
    exp_q.delete();
    m_state = 0;
    m_edit  = 0;
    for (int op = 0; op < 100; op++) begin
      int kind, reps, mask;
      bit r, m, i, x;
      kind = $urandom_range(0, 9);
      reps = 1;
      r = 0; m = 0; i = 0; x = 0;
      case (kind)
        0, 1:    r = 1;
        2, 3:    m = 1;
        4, 5, 6: i = 1;
        7: begin i = 1; reps = $urandom_range(2, 70); end
        8: begin
          mask = $urandom_range(1, 7);
          r = mask[0]; m = mask[1]; i = mask[2];
        end
        default: x = 1;
      endcase
      for (int p = 0; p < reps; p++) begin
        model(r, m, i, x);
        press(r, m, i, x, $urandom_range(1, 4));
      end
      check($sformatf("rand%0d mode", op), int'(bus.mode), m_state);
      check($sformatf("rand%0d data", op), int'(bus.data), to_bcd(m_edit));
      check($sformatf("rand%0d enable", op), int'(bus.enable), (m_state == 1) ? 1 : 0);
      check_loads($sformatf("rand%0d", op));
    end

    check("strobe exclusivity violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
